// File: rtl/seg_scan_reader_pkg.sv
// Shared constants for the segment scan reader: active-low segment patterns,
// special digit codes and the frame FSM encoding.
package seg_scan_reader_pkg;

    // Segment order is {a,b,c,d,e,f,g}; a 0 bit means the segment is lit.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] ERR_CODE   = 4'hE;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_reader_seg_to_bcd.sv
// Combinational segment-pattern to digit lookup; unknown patterns map to
// ERR_CODE with valid low.
module seg_to_bcd
    import seg_scan_reader_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = ERR_CODE;
        valid = 1'b1;
        case (seg)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: digit = BLANK_CODE;
            default: begin
                digit = ERR_CODE;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Captures a four-digit multiplexed 7-segment display: debounces each digit,
// assembles a frame in a shadow register and presents it with a valid/ready handshake.
module seg_scan_reader
    import seg_scan_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  dig_sel,
    input  logic        out_ready,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        err,
    output logic        overrun
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [6:0]      prev_seg_q;
    logic [3:0]      prev_sel_q;
    logic            prev_q;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0]      seen_q, seen_set, seen_d;
    logic            one_hot, same, accept, frame_done;
    logic            load, discard;
    logic [3:0]      dec_digit;
    logic            dec_ok;

    seg_to_bcd u_dec (
        .seg   (seg_in),
        .digit (dec_digit),
        .valid (dec_ok)
    );

    assign one_hot = (dig_sel != 4'b0000) && ((dig_sel & (dig_sel - 4'd1)) == 4'b0000);
    assign same    = prev_q && (seg_in == prev_seg_q) && (dig_sel == prev_sel_q);

    always_comb begin
        cnt_d = cnt_q;
        if (!one_hot)
            cnt_d = 4'd0;
        else if (!same)
            cnt_d = 4'd1;
        else if (cnt_q != STABLE)
            cnt_d = cnt_q + 4'd1;
    end

    // A saturated counter holding at STABLE must not fire again; a fresh
    // sample landing straight on STABLE (STABLE_CYCLES=1) still must.
    assign accept = one_hot && (cnt_d == STABLE) && !(same && (cnt_q == STABLE));

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < 4; i++)
            if (accept && dig_sel[i])
                shadow_d[i] = dec_digit;
    end

    assign seen_set   = seen_q | (accept ? dig_sel : 4'b0000);
    assign frame_done = &seen_set;
    assign seen_d     = frame_done ? 4'b0000 : seen_set;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        discard = 1'b0;
        case (state_q)
            COLLECT: begin
                if (frame_done) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (frame_done)
                        load = 1'b1;
                    else
                        state_d = COLLECT;
                end else if (frame_done) begin
                    discard = 1'b1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            cnt_q      <= 4'd0;
            prev_seg_q <= 7'd0;
            prev_sel_q <= 4'd0;
            prev_q     <= 1'b0;
            shadow_q   <= '0;
            seen_q     <= 4'd0;
            value      <= 16'h0000;
            err        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_seg_q <= seg_in;
            prev_sel_q <= dig_sel;
            prev_q     <= one_hot;
            shadow_q   <= shadow_d;
            seen_q     <= seen_d;
            overrun    <= discard;
            if (load)
                value <= shadow_d;
            if (accept && !dec_ok)
                err <= 1'b1;
        end
    end

    assign value_valid = (state_q == PRESENT);

endmodule

// File: doc/seg_scan_reader.md
SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive identical sample cycles required before a digit is accepted (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seg_in  input  7  multiplexed segment bus, active-low (0 = lit), bit6 = a ... bit0 = g.
REQ-005 dig_sel  input  4  digit strobe, active-high, one-hot; bit3 = most significant digit.
REQ-006 out_ready  input  1  consumer accepts value when high with value_valid.
REQ-007 value  output  16  four captured digits, digit3 in [15:12] ... digit0 in [3:0].
REQ-008 value_valid  output  1  value holds a complete frame.
REQ-009 err  output  1  sticky flag: an accepted digit had an undefined pattern.
REQ-010 overrun  output  1  one-cycle pulse: completed frame discarded due to backpressure.

Function
REQ-011 Sample (seg_in, dig_sel) every cycle; a sample is qualified only if dig_sel is exactly one-hot.
REQ-012 Stability counter increments while the qualified sample equals the previous cycle's sample, restarts at 1 on any change, and clears to 0 on a non-one-hot dig_sel.
REQ-013 A digit is accepted on the cycle the counter reaches STABLE_CYCLES; it saturates there, so each stable period yields exactly one acceptance.
REQ-014 Decoding: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111111 (blank)->4'hF.
REQ-015 Any other pattern decodes to 4'hE and sets err on acceptance; err clears only on rst.
REQ-016 Accepted digit is written into the shadow slot selected by dig_sel and that slot's seen bit is set; a repeated slot overwrites.
REQ-017 Frame complete when all four seen bits are set; seen bits clear on the same cycle.
REQ-018 FSM states: COLLECT (value_valid=0) and PRESENT (value_valid=1); collection continues in both.
REQ-019 COLLECT + frame complete -> load value from shadow (including a digit accepted that cycle), go PRESENT on next cycle.
REQ-020 PRESENT + out_ready -> handshake completes; return to COLLECT unless a frame completes in the same cycle, in which case load new value and stay PRESENT.
REQ-021 PRESENT + !out_ready + frame complete -> frame discarded, value unchanged, overrun pulses for one cycle.
REQ-022 value is stable while value_valid=1 and out_ready=0.
REQ-023 Latency: value_valid rises one cycle after the accepting edge of the fourth digit.

Reset
REQ-024 On rst: state COLLECT, value=16'h0000, value_valid=0, err=0, overrun=0, shadow=0, seen bits=0, stability counter=0.
REQ-025 rst mid-frame discards partially collected digits; rst overrides all simultaneous events.

Structure
REQ-026 Shared package holds segment pattern constants for 0-9 and blank, BLANK_CODE=4'hF, ERR_CODE=4'hE, and FSM state encoding.
REQ-027 Combinational pattern-to-digit lookup is a sub-module seg_to_bcd (7-bit in, 4-bit digit plus valid out); the counter, shadow register and FSM stay in the top.

Verification
REQ-028 Drive digits 1,2,3,4 on dig_sel 1000,0100,0010,0001, 4 cycles each, out_ready=1 -> value=16'h1234, value_valid high one cycle, err=0.
REQ-029 Glitch seg_in=0000000 on digit0 for 3 cycles, then 0000110 for 4 -> digit0=3; glitch never accepted.
REQ-030 Pattern 1111110 on digit2 for 4 cycles within a frame -> value[11:8]=4'hE, err=1 until rst.
REQ-031 out_ready=0, two complete frames 1234 then 5678 -> value stays 16'h1234, overrun one-cycle pulse at second completion; out_ready=1 -> value_valid drops next cycle.
REQ-032 rst asserted after two digits of a frame, then full frame 9,8,7,blank -> value=16'h987F; no stale digits.
REQ-033 dig_sel=0000 or 0011 for 10 cycles with any seg_in -> no acceptance, counter cleared.
